core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
// PURPOSE
//   Synthesisable run-control and trace-capture unit placed beside core_top.
//   Sequences the core's reset, counts run cycles, and detects end-of-test: PC stuck (self-loop) or watchdog timeout.
//   Records every run-cycle {pc, instr} into a circular trace buffer that a bench or debug host drains.
//   Replaces the fixed-delay, display-only test harness with a parametrised, checkable block.
// PARAMETERS
//   XLEN         32   width of pc_i / trace_rd_pc
//   RST_CYCLES   2    cycles core_rst_n is held low in RESET (>=1)
//   TIMEOUT      20   max RUN cycles before forced stop (>=1, <2^32)
//   HALT_REPEAT  3    consecutive cycles with pc_i == previous pc_i that declare a halt (>=1)
//   TRACE_DEPTH  16   trace entries, power of two, >=2
// PORTS
//   clk             in   1     clock
//   rst_n           in   1     async active-low reset
//   start           in   1     1-cycle request to begin a run
//   pc_i            in   XLEN  core PC, sampled every RUN cycle
//   instr_i         in   32    core fetched instruction, sampled with pc_i
//   core_rst_n      out  1     reset to core_top, active low
//   busy            out  1     high in RESET or RUN
//   done            out  1     high in DONE
//   timeout         out  1     run ended by watchdog (valid while done)
//   halt_pc         out  XLEN  PC at halt detection (valid when done & !timeout)
//   cycle_cnt       out  32    RUN cycles elapsed in current/last run
//   trace_rd_en     in   1     pop oldest trace entry
//   trace_rd_valid  out  1     trace_rd_pc/instr valid this cycle
//   trace_rd_pc     out  XLEN  popped PC
//   trace_rd_instr  out  32    popped instruction
//   trace_count     out  $clog2(TRACE_DEPTH)+1  entries held
//   trace_overflow  out  1     sticky: an entry was overwritten this run
// BEHAVIOUR
//   Reset (rst_n=0, async): state IDLE; core_rst_n=0; busy=done=timeout=0; halt_pc=0; cycle_cnt=0;
//     trace empty, trace_count=0, trace_overflow=0, trace_rd_valid=0, rd data=0. Mid-run reset aborts at once.
//   FSM IDLE->RESET on start. RESET: core_rst_n=0 for exactly RST_CYCLES cycles, then RUN.
//   Entering RESET clears cycle_cnt, timeout, halt_pc, trace_overflow, repeat counter, and trace pointers.
//   RUN: core_rst_n=1; each cycle cycle_cnt+=1, {pc_i,instr_i} written to trace; repeat counter +1 if pc_i equals
//     last RUN-cycle pc_i else cleared (first RUN cycle never compares).
//   Halt: repeat counter reaches HALT_REPEAT -> DONE next edge, halt_pc=pc_i, timeout=0.
//   Timeout: cycle_cnt reaches TIMEOUT in the same cycle -> DONE, timeout=1. Both together: halt wins.
//   DONE: core_rst_n=0, done=1, flags/trace/cycle_cnt hold; start -> RESET (new run). start in RESET/RUN ignored.
//   Trace ring: write when full drops oldest (rd ptr advances), trace_overflow=1, count stays TRACE_DEPTH.
//   Read: trace_rd_en with count>0 -> data registered, trace_rd_valid=1 next cycle only; empty pop ignored.
//   Read+write same cycle: both performed; count unchanged; if full, rd ptr advances once (popped entry = oldest).
//   Pointers wrap modulo TRACE_DEPTH; reads allowed in any state.
// CONFIGURATION
//   CORE_RUN_CTRL_DISPLAY_EN defined: simulation-only $display per RUN cycle "PC=%x,instr=%x", plus one
//     line on DONE giving cause, cycle_cnt, halt_pc. Undefined: no display code; RTL behaviour identical.
// STRUCTURE
//   Header run_ctrl_defs.v: FSM state encodings (IDLE=0,RESET=1,RUN=2,DONE=3), TRACE_W = XLEN+32 helper.
//   Sub-module run_trace_fifo: overwrite-on-full ring buffer (wr, rd, flush, count, overflow), DEPTH/width params.
//   Top holds FSM, counters, halt detector, output regs.
// TESTING
//   start, pc_i = 0,4,8,...,0x20,0x20,0x20,0x20 -> core_rst_n low 2 cycles, done after 3 repeats, halt_pc=0x20, timeout=0.
//   pc_i increments forever, TIMEOUT=20 -> done at cycle_cnt=20, timeout=1, trace_overflow=1, trace_count=16.
//   Drain after overflow run -> 16 pops return pc 0x10..0x4C in order, then empty, pop ignored, valid=0.
//   Halt and timeout on same cycle (TIMEOUT=5, pc fixed from cycle 2) -> timeout=0, halt_pc correct.
//   Assert rst_n low mid-RUN -> all outputs to reset values asynchronously; start afterwards runs cleanly.
//   Full buffer, trace_rd_en during RUN write -> count stays 16, popped entries stay contiguous, oldest first.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the run-control block: FSM encoding and trace entry width helper.
// Pure declarations, no logic.
package core_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int INSTR_W = 32;

    function automatic int trace_w(input int xlen);
        return xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Trace drain port: the host pops {pc, instr} entries and watches occupancy/overflow.
// slave = run-control side, master = draining host.
interface core_run_ctrl_if #(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16
);
    logic                           trace_rd_en;
    logic                           trace_rd_valid;
    logic [XLEN-1:0]                trace_rd_pc;
    logic [31:0]                    trace_rd_instr;
    logic [$clog2(TRACE_DEPTH):0]   trace_count;
    logic                           trace_overflow;

    modport slave (
        input  trace_rd_en,
        output trace_rd_valid, trace_rd_pc, trace_rd_instr, trace_count, trace_overflow
    );

    modport master (
        output trace_rd_en,
        input  trace_rd_valid, trace_rd_pc, trace_rd_instr, trace_count, trace_overflow
    );
endinterface

// File: rtl/core_run_ctrl_trace_fifo.sv
// Overwrite-on-full ring buffer holding run trace entries; write when full drops the oldest.
// Latency: pop data registered, rd_vld one cycle after rd with count>0.
// Backpressure: none; writer never stalls, overflow flag records dropped entries.
module core_run_ctrl_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        wr_dat,
    input  logic                    rd,
    input  logic                    flush,
    output logic                    rd_vld,
    output logic [WIDTH-1:0]        rd_dat,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             drop;

    assign full = (count == (PW+1)'(DEPTH));
    assign pop  = rd && (count != '0);
    // A concurrent pop consumes the oldest entry, so nothing is lost in that case.
    assign drop = wr && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_vld   <= 1'b0;
            rd_dat   <= '0;
        end else begin
            rd_vld <= pop;
            if (pop) rd_dat <= mem[rd_ptr];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (pop || (wr && full)) rd_ptr <= rd_ptr + 1'b1;
                if (drop) overflow <= 1'b1;
                if (wr && !full && !pop) count <= count + 1'b1;
                else if (pop && !wr)     count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run control for core_top: sequences core reset, counts run cycles, stops on PC self-loop or watchdog, traces {pc,instr}.
// Latency: done asserts the edge after the halting/timeout RUN cycle; trace pops return data next cycle.
// Backpressure: none; trace overwrites oldest when full. Optional CORE_RUN_CTRL_DISPLAY_EN adds sim-only prints.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 20,
    parameter int HALT_REPEAT = 3,
    parameter int TRACE_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [XLEN-1:0]  halt_pc,
    output logic [31:0]      cycle_cnt,
    core_run_ctrl_if.slave   trace
);
    localparam int TW    = trace_w(XLEN);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [RC_W-1:0]  rst_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nxt;
    logic [XLEN-1:0]  last_pc;
    logic             first_q;
    logic [31:0]      cnt_nxt;
    logic             run;
    logic             enter;
    logic             rst_done;
    logic             halt_hit;
    logic             to_hit;
    logic [TW-1:0]    rd_dat;

    assign run      = (state == ST_RUN);
    assign enter    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign rst_done = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign cnt_nxt  = cycle_cnt + 32'd1;
    assign halt_hit = run && (rep_nxt == REP_W'(HALT_REPEAT));
    assign to_hit   = run && (cnt_nxt == 32'(TIMEOUT));

    // The first RUN cycle has no predecessor, so it never counts as a repeat.
    always_comb begin
        rep_nxt = '0;
        if (!first_q && (pc_i == last_pc)) rep_nxt = rep_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RESET;
            ST_RESET: if (rst_done) state_nxt = ST_RUN;
            ST_RUN:   if (halt_hit || to_hit) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RESET;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        core_rst_n = run;
        busy       = (state == ST_RESET) || run;
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            halt_pc   <= '0;
            rep_cnt   <= '0;
            last_pc   <= '0;
            first_q   <= 1'b1;
        end else if (enter) begin
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            halt_pc   <= '0;
            rep_cnt   <= '0;
            first_q   <= 1'b1;
        end else if (state == ST_RESET) begin
            rst_cnt <= rst_cnt + 1'b1;
        end else if (run) begin
            cycle_cnt <= cnt_nxt;
            rep_cnt   <= rep_nxt;
            last_pc   <= pc_i;
            first_q   <= 1'b0;
            // Halt takes priority when both conditions land on the same cycle.
            if (halt_hit) begin
                halt_pc <= pc_i;
                timeout <= 1'b0;
            end else if (to_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    core_run_ctrl_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TW)
    ) u_trace (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (run),
        .wr_dat   ({pc_i, instr_i}),
        .rd       (trace.trace_rd_en),
        .flush    (enter),
        .rd_vld   (trace.trace_rd_valid),
        .rd_dat   (rd_dat),
        .count    (trace.trace_count),
        .overflow (trace.trace_overflow)
    );

    assign trace.trace_rd_pc    = rd_dat[TW-1:32];
    assign trace.trace_rd_instr = rd_dat[31:0];

`ifdef CORE_RUN_CTRL_DISPLAY_EN
    always @(posedge clk) begin
        if (rst_n && run) begin
            $display("PC=%x,instr=%x", pc_i, instr_i);
            if (halt_hit || to_hit)
                $display("core_run_ctrl done: cause=%s cycle_cnt=%0d halt_pc=%x",
                         halt_hit ? "halt" : "timeout", cnt_nxt, halt_hit ? pc_i : halt_pc);
        end
    end
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: halt, timeout, trace drain, halt/timeout tie, async abort, full-buffer pop during RUN.
module tb_core_run_ctrl;
    localparam int XLEN = 32;
    localparam int TD   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [XLEN-1:0]   pc_i;
    logic [31:0]       instr_i;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [XLEN-1:0]   halt_pc;
    logic [31:0]       cycle_cnt;

    int checks = 0;
    int errors = 0;

    core_run_ctrl_if #(.XLEN(XLEN), .TRACE_DEPTH(TD)) tif ();

    core_run_ctrl #(
        .XLEN(XLEN), .RST_CYCLES(2), .TIMEOUT(20), .HALT_REPEAT(3), .TRACE_DEPTH(TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .halt_pc    (halt_pc),
        .cycle_cnt  (cycle_cnt),
        .trace      (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst_n"}, core_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_halt_pc"}, halt_pc, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_count"}, tif.trace_count, 0);
        chk({tag, "_overflow"}, tif.trace_overflow, 0);
        chk({tag, "_rd_valid"}, tif.trace_rd_valid, 0);
        chk({tag, "_rd_pc"}, tif.trace_rd_pc, 0);
    endtask

    // start pulse, then two core-reset cycles, then RUN
    task automatic run_start(input string tag);
        start = 1'b1;
        step;
        start = 1'b0;
        chk({tag, "_rst1_core_rst_n"}, core_rst_n, 0);
        chk({tag, "_rst1_busy"}, busy, 1);
        chk({tag, "_rst1_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_rst1_overflow"}, tif.trace_overflow, 0);
        chk({tag, "_rst1_count"}, tif.trace_count, 0);
        chk({tag, "_rst1_timeout"}, timeout, 0);
        step;
        chk({tag, "_rst2_core_rst_n"}, core_rst_n, 0);
        step;
        chk({tag, "_run_core_rst_n"}, core_rst_n, 1);
        chk({tag, "_run_busy"}, busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pc_i = '0;
        instr_i = '0;
        tif.trace_rd_en = 1'b0;
        #3;
        chk_reset_vals("por");
        step;
        rst_n = 1'b1;
        step;
        chk("idle_core_rst_n", core_rst_n, 0);

        // halt on PC self-loop at 0x20
        run_start("t1");
        for (int i = 0; i < 12; i++) begin
            pc_i = (i < 9) ? 32'(i * 4) : 32'h20;
            instr_i = 32'h13 + 32'(i);
            step;
            chk("t1_done", done, (i == 11) ? 1 : 0);
        end
        chk("t1_halt_pc", halt_pc, 32'h20);
        chk("t1_timeout", timeout, 0);
        chk("t1_cycle_cnt", cycle_cnt, 12);
        chk("t1_count", tif.trace_count, 12);
        chk("t1_overflow", tif.trace_overflow, 0);
        chk("t1_core_rst_n", core_rst_n, 0);
        chk("t1_busy", busy, 0);
        tif.trace_rd_en = 1'b1;
        step;
        tif.trace_rd_en = 1'b0;
        chk("t1_pop_valid", tif.trace_rd_valid, 1);
        chk("t1_pop_pc", tif.trace_rd_pc, 0);
        chk("t1_pop_instr", tif.trace_rd_instr, 32'h13);
        chk("t1_pop_count", tif.trace_count, 11);
        step;
        chk("t1_valid_drop", tif.trace_rd_valid, 0);

        // watchdog timeout, start mid-run ignored
        run_start("t2");
        for (int i = 0; i < 20; i++) begin
            pc_i = 32'(i * 4);
            instr_i = 32'h1000 + 32'(i);
            start = (i == 5);
            step;
            start = 1'b0;
            if (i == 5) chk("t2_start_ignored", cycle_cnt, 6);
        end
        chk("t2_done", done, 1);
        chk("t2_timeout", timeout, 1);
        chk("t2_cycle_cnt", cycle_cnt, 20);
        chk("t2_overflow", tif.trace_overflow, 1);
        chk("t2_count", tif.trace_count, 16);
        pc_i = 32'h999;
        step;
        step;
        chk("t2_hold_cnt", cycle_cnt, 20);
        chk("t2_hold_count", tif.trace_count, 16);
        chk("t2_hold_done", done, 1);

        // drain the overflowed ring: oldest surviving entry is pc 0x10
        tif.trace_rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step;
            chk("t3_valid", tif.trace_rd_valid, 1);
            chk("t3_pc", tif.trace_rd_pc, 32'h10 + 32'(4 * k));
            chk("t3_instr", tif.trace_rd_instr, 32'h1004 + 32'(k));
            chk("t3_count", tif.trace_count, 15 - k);
        end
        step;
        chk("t3_empty_valid", tif.trace_rd_valid, 0);
        chk("t3_empty_count", tif.trace_count, 0);
        tif.trace_rd_en = 1'b0;

        // halt and timeout on the same cycle: halt wins
        run_start("t4");
        for (int i = 0; i < 20; i++) begin
            pc_i = 32'h100 + 32'(4 * ((i < 17) ? i : 16));
            instr_i = 32'h2000 + 32'(i);
            step;
            chk("t4_done", done, (i == 19) ? 1 : 0);
        end
        chk("t4_timeout", timeout, 0);
        chk("t4_halt_pc", halt_pc, 32'h140);
        chk("t4_cycle_cnt", cycle_cnt, 20);

        // asynchronous abort mid-RUN
        run_start("t5");
        for (int i = 0; i < 5; i++) begin
            pc_i = 32'h300 + 32'(4 * i);
            step;
        end
        chk("t5_cnt_before", cycle_cnt, 5);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("t5");
        rst_n = 1'b1;
        step;
        chk("t5_idle_busy", busy, 0);

        // full ring with pops during RUN writes
        run_start("t6");
        for (int i = 0; i < 16; i++) begin
            pc_i = 32'h200 + 32'(4 * i);
            instr_i = 32'h3000 + 32'(i);
            step;
        end
        chk("t6_full_count", tif.trace_count, 16);
        chk("t6_full_overflow", tif.trace_overflow, 0);
        tif.trace_rd_en = 1'b1;
        for (int i = 16; i < 20; i++) begin
            pc_i = 32'h200 + 32'(4 * i);
            instr_i = 32'h3000 + 32'(i);
            step;
            chk("t6_rw_valid", tif.trace_rd_valid, 1);
            chk("t6_rw_pc", tif.trace_rd_pc, 32'h200 + 32'(4 * (i - 16)));
            chk("t6_rw_count", tif.trace_count, 16);
        end
        tif.trace_rd_en = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_timeout", timeout, 1);
        step;
        tif.trace_rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step;
            chk("t6_drain_pc", tif.trace_rd_pc, 32'h210 + 32'(4 * k));
        end
        tif.trace_rd_en = 1'b0;
        step;
        chk("t6_drain_count", tif.trace_count, 0);
        chk("t6_drain_valid", tif.trace_rd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
